// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_pkg
//  Description : Shared types and helpers for the sequential shift-add
//                multiplier (FSM state encoding, counter width helper).
//  Revision    : 1.0  - initial release
// ============================================================================
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_mult_state_t;

    // Bits needed for a down-counter that starts at width-1; never below 1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Sequential shift-add multiplier. Captures a/b on an accepted
//                start, walks one multiplier bit per clock and presents the
//                registered product with a one-cycle done pulse.
//                Optional macro SEQ_MULT_SIGNED_EN selects two's-complement
//                operands (sign-magnitude internally); default is unsigned.
//  Revision    : 1.0  - initial release
// ============================================================================
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = INPUT_WIDTH * 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [INPUT_WIDTH-1:0]  a,
    input  logic [INPUT_WIDTH-1:0]  b,
    output logic                    busy,
    output logic                    done,
    output logic [OUTPUT_WIDTH-1:0] product
);

    localparam int                CNT_W      = cnt_width(INPUT_WIDTH);
    localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'(INPUT_WIDTH - 1);

    generate
        if (INPUT_WIDTH < 2) begin : g_bad_input_width
            $error("seq_multiplier: INPUT_WIDTH must be >= 2");
        end
        if (OUTPUT_WIDTH < 2 * INPUT_WIDTH) begin : g_bad_output_width
            $error("seq_multiplier: OUTPUT_WIDTH must be >= 2*INPUT_WIDTH");
        end
    endgenerate

    seq_mult_state_t         r_state;
    seq_mult_state_t         w_state_next;
    logic                    w_accept;
    logic                    w_last;
    logic                    r_busy;
    logic                    r_done;
    logic [OUTPUT_WIDTH-1:0] r_acc;
    logic [OUTPUT_WIDTH-1:0] r_mcand;
    logic [OUTPUT_WIDTH-1:0] r_product;
    logic [OUTPUT_WIDTH-1:0] w_acc_next;
    logic [OUTPUT_WIDTH-1:0] w_result;
    logic [INPUT_WIDTH-1:0]  r_mplier;
    logic [INPUT_WIDTH-1:0]  w_mag_a;
    logic [INPUT_WIDTH-1:0]  w_mag_b;
    logic [CNT_W-1:0]        r_cnt;

    assign w_last     = (r_cnt == '0);
    // Multiplicand register is pre-shifted each cycle, so it already sits at
    // the current bit index when added.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_sign;

    // Most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_mag_a  = a[INPUT_WIDTH-1] ? -a : a;
    assign w_mag_b  = b[INPUT_WIDTH-1] ? -b : b;
    // Full-width negation yields the sign-extended two's-complement product.
    assign w_result = r_sign ? -w_acc_next : w_acc_next;

    // Result sign is captured alongside the operand magnitudes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= a[INPUT_WIDTH-1] ^ b[INPUT_WIDTH-1];
        end
    end
`else
    assign w_mag_a  = a;
    assign w_mag_b  = b;
    assign w_result = w_acc_next;
`endif

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == CALC);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shift-add datapath: load on accept, one multiplier bit per CALC cycle,
    // product captured only on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_mcand   <= OUTPUT_WIDTH'(w_mag_a);
            r_mplier  <= w_mag_b;
            r_cnt     <= c_cnt_init;
        end else if (r_state == CALC) begin
            r_acc     <= w_acc_next;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_cnt     <= r_cnt - 1'b1;
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire
